// File: rtl/arm_isa_pkg.sv
// ARM subset constants shared by the instruction encoder/loader and the decoder.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: instruction class codes, ALU cmd nibbles, loader FSM state encoding,
//   MUL marker nibble, packed field bundle and the ALU selector -> cmd helper.
package arm_isa_pkg;

   // Instruction classes as carried on in_cls; 6 and 7 are illegal.
   localparam logic [2:0] CLS_DP_REG = 3'd0;
   localparam logic [2:0] CLS_DP_IMM = 3'd1;
   localparam logic [2:0] CLS_MUL    = 3'd2;
   localparam logic [2:0] CLS_LDR    = 3'd3;
   localparam logic [2:0] CLS_STR    = 3'd4;
   localparam logic [2:0] CLS_B      = 3'd5;

   // Data-processing opcode field [24:21].
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // Bits [7:4] of a multiply; the decoder keys its IsMul check on this nibble.
   localparam logic [3:0] MUL_MARKER = 4'b1001;

   // Loader FSM state encoding.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERROR = 3'd4;

   typedef struct packed {
      logic [2:0]  cls;
      logic [3:0]  cond;
      logic [1:0]  alu;
      logic        s;
      logic [3:0]  rd;
      logic [3:0]  rn;
      logic [3:0]  rm;
      logic [23:0] imm;
   } fields_t;

   function automatic logic [3:0] alu_cmd(input logic [1:0] alu);
      case (alu)
         2'd0:    alu_cmd = CMD_ADD;
         2'd1:    alu_cmd = CMD_SUB;
         2'd2:    alu_cmd = CMD_AND;
         default: alu_cmd = CMD_ORR;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field stream in, memory write port out, for the instruction loader.
// Latency: n/a (signal bundle).
// Backpressure: in_valid/in_ready on the field stream; the write port has none.
// master = program source (drives fields, observes writes); slave = loader.
interface instr_encoder_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_cls;
   logic [3:0]  in_cond;
   logic [1:0]  in_alu;
   logic        in_s;
   logic [3:0]  in_rd;
   logic [3:0]  in_rn;
   logic [3:0]  in_rm;
   logic [23:0] in_imm;
   logic        in_last;
   logic        mem_we;
   logic [31:0] mem_adr;
   logic [31:0] mem_wd;

   modport master (
      output in_valid, in_cls, in_cond, in_alu, in_s, in_rd, in_rn, in_rm, in_imm, in_last,
      input  in_ready, mem_we, mem_adr, mem_wd
   );

   modport slave (
      input  in_valid, in_cls, in_cond, in_alu, in_s, in_rd, in_rn, in_rm, in_imm, in_last,
      output in_ready, mem_we, mem_adr, mem_wd
   );
endinterface

// File: rtl/instr_encoder.sv
// Combinational encoder: decoded fields -> 32-bit ARM word plus an illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: f (field bundle) in; word (encoded instruction), illegal (bad class or
//   immediate too wide for the class) out.
module instr_encoder
   import arm_isa_pkg::*;
(
   input  fields_t     f,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (f.cls)
         CLS_DP_REG: word = {f.cond, 2'b00, 1'b0, alu_cmd(f.alu), f.s, f.rn, f.rd, 8'h00, f.rm};
         CLS_DP_IMM: begin
            word    = {f.cond, 2'b00, 1'b1, alu_cmd(f.alu), f.s, f.rn, f.rd, 4'h0, f.imm[7:0]};
            illegal = |f.imm[23:8];
         end
         // Note the register swap: Rd sits in [19:16] and Rn in [3:0] for MUL.
         CLS_MUL:    word = {f.cond, 6'b000000, 1'b0, f.s, f.rd, 4'h0, f.rm, MUL_MARKER, f.rn};
         // Single data transfer with I=0, P=1, U=1, B=0, W=0; L selects load.
         CLS_LDR: begin
            word    = {f.cond, 8'b0101_1001, f.rn, f.rd, f.imm[11:0]};
            illegal = |f.imm[23:12];
         end
         CLS_STR: begin
            word    = {f.cond, 8'b0101_1000, f.rn, f.rd, f.imm[11:0]};
            illegal = |f.imm[23:12];
         end
         CLS_B:      word = {f.cond, 4'b1010, f.imm};
         default:    illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads a program into memory: accepts field beats, encodes, writes words sequentially.
// Latency: beat accepted at edge N -> mem_we high during cycle N+1; 1 word per 2 cycles.
// Backpressure: in_ready high only in RECV, so it drops for the write cycle after each accept.
// Ports: clk, reset (sync, active-high), start pulse; bus (slave: field stream + write port);
//   busy, done (1-cycle pulse), err (held in ERROR until start/reset), word_count.
module instr_encoder_loader
   import arm_isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          MAX_WORDS = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   instr_encoder_loader_if.slave bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [6:0]           word_count
);

   logic [2:0]  state_q, state_d;
   logic [6:0]  count_q, count_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wd_q, wd_d;
   logic        last_q, last_d;

   fields_t     fld;
   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        full;

   assign fld = '{cls: bus.in_cls, cond: bus.in_cond, alu: bus.in_alu, s: bus.in_s,
                  rd: bus.in_rd, rn: bus.in_rn, rm: bus.in_rm, imm: bus.in_imm};

   instr_encoder u_enc (
      .f       (fld),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   // Count only advances in WRITE, so it is stable while RECV evaluates room.
   assign full = (count_q == 7'(MAX_WORDS));

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      adr_d   = adr_q;
      wd_d    = wd_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (state_q == ST_DONE) state_d = ST_IDLE;
            if (start) begin
               state_d = ST_RECV;
               count_d = '0;
            end
         end
         ST_RECV: begin
            if (bus.in_valid) begin
               // An erroring beat writes nothing and its in_last is discarded.
               if (enc_illegal || full) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d = ST_WRITE;
                  adr_d   = BASE_ADDR + {23'd0, count_q, 2'b00};
                  wd_d    = enc_word;
                  last_d  = bus.in_last;
               end
            end
         end
         ST_WRITE: begin
            count_d = count_q + 7'd1;
            state_d = last_q ? ST_DONE : ST_RECV;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         adr_q   <= '0;
         wd_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         adr_q   <= adr_d;
         wd_q    <= wd_d;
         last_q  <= last_d;
      end
   end

   assign bus.in_ready = (state_q == ST_RECV);
   assign bus.mem_we   = (state_q == ST_WRITE);
   assign bus.mem_adr  = adr_q;
   assign bus.mem_wd   = wd_q;
   assign busy         = (state_q == ST_RECV) || (state_q == ST_WRITE);
   assign done         = (state_q == ST_DONE);
   assign err          = (state_q == ST_ERROR);
   assign word_count   = count_q;

endmodule
